// File: rtl/rate_divided_counter.sv
// 4-bit up-counter advanced by a selectable-rate divider (every clock, or 1x/2x/4x TICK_BASE).
// Optional macro RATE_COUNTER_HEX_EN adds a registered active-low 7-segment output hex0.
module rate_divided_counter #(
    parameter int TICK_BASE = 50000000,
    parameter int DIV_W     = 28
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       enable,
    input  logic [1:0] speed,
    input  logic       load,
    input  logic [3:0] load_value,
    output logic [3:0] count,
    output logic       tick,
`ifdef RATE_COUNTER_HEX_EN
    output logic [6:0] hex0,
`endif
    output logic       wrap
);

    localparam logic [DIV_W-1:0] P1_M1 = DIV_W'(TICK_BASE - 1);
    localparam logic [DIV_W-1:0] P2_M1 = DIV_W'(2 * TICK_BASE - 1);
    localparam logic [DIV_W-1:0] P4_M1 = DIV_W'(4 * TICK_BASE - 1);

    logic [3:0]       count_reg, count_next;
    logic [DIV_W-1:0] div_reg, div_next;
    logic             tick_reg, tick_next;
    logic             wrap_reg, wrap_next;
    logic [DIV_W-1:0] period_m1;
    logic             terminal;

    always_comb begin
        period_m1 = '0;
        case (speed)
            2'b00:   period_m1 = '0;
            2'b01:   period_m1 = P1_M1;
            2'b10:   period_m1 = P2_M1;
            default: period_m1 = P4_M1;
        endcase
    end

    // >= rather than == so a switch to a shorter period fires immediately.
    assign terminal = (div_reg >= period_m1);

    always_comb begin
        count_next = count_reg;
        div_next   = div_reg;
        tick_next  = 1'b0;
        wrap_next  = 1'b0;
        if (load) begin
            count_next = load_value;
            div_next   = '0;
        end else if (enable) begin
            if (terminal) begin
                div_next   = '0;
                count_next = count_reg + 4'd1;
                tick_next  = 1'b1;
                wrap_next  = (count_reg == 4'hF);
            end else begin
                div_next = div_reg + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_reg <= '0;
            div_reg   <= '0;
            tick_reg  <= 1'b0;
            wrap_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            div_reg   <= div_next;
            tick_reg  <= tick_next;
            wrap_reg  <= wrap_next;
        end
    end

    assign count = count_reg;
    assign tick  = tick_reg;
    assign wrap  = wrap_reg;

`ifdef RATE_COUNTER_HEX_EN
    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        logic [6:0] s;
        s = 7'b1111111;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Decoded from count_next so the glyph changes on the same edge as count.
    logic [6:0] hex_reg;
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) hex_reg <= 7'b1000000;
        else         hex_reg <= hex_seg(count_next);
    end
    assign hex0 = hex_reg;
`endif

endmodule

// File: tb/tb_rate_divided_counter.sv
// Randomized scoreboard bench for rate_divided_counter (TICK_BASE = 4); honours RATE_COUNTER_HEX_EN.
module tb_rate_divided_counter;

    localparam int TB = 4;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] speed = 2'b00;
    logic       load = 1'b0;
    logic [3:0] load_value = 4'd0;
    logic [3:0] count;
    logic       tick;
    logic       wrap;
`ifdef RATE_COUNTER_HEX_EN
    logic [6:0] hex0;
`endif

    rate_divided_counter #(.TICK_BASE(TB), .DIV_W(28)) dut (
        .clock(clock),
        .resetn(resetn),
        .enable(enable),
        .speed(speed),
        .load(load),
        .load_value(load_value),
        .count(count),
        .tick(tick),
`ifdef RATE_COUNTER_HEX_EN
        .hex0(hex0),
`endif
        .wrap(wrap)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] count;
        logic       tick;
        logic       wrap;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: count of enabled cycles since the last advance, period from speed.
    int m_count = 0;
    int m_elapsed = 0;
    int m_tick = 0;
    int m_wrap = 0;

    function automatic int period_of(input logic [1:0] sp);
        case (sp)
            2'b00:   return 1;
            2'b01:   return TB;
            2'b10:   return 2 * TB;
            default: return 4 * TB;
        endcase
    endfunction

`ifdef RATE_COUNTER_HEX_EN
    function automatic logic [6:0] glyph(input int v);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[v];
    endfunction
`endif

    task automatic model_reset();
        m_count = 0; m_elapsed = 0; m_tick = 0; m_wrap = 0;
    endtask

    task automatic model_step();
        if (!resetn) begin
            model_reset();
        end else if (load) begin
            m_count = int'(load_value); m_elapsed = 0; m_tick = 0; m_wrap = 0;
        end else if (!enable) begin
            m_tick = 0; m_wrap = 0;
        end else if (m_elapsed + 1 >= period_of(speed)) begin
            m_wrap = (m_count == 15) ? 1 : 0;
            m_count = (m_count + 1) % 16;
            m_elapsed = 0;
            m_tick = 1;
        end else begin
            m_elapsed = m_elapsed + 1;
            m_tick = 0; m_wrap = 0;
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.count = 4'(m_count);
        e.tick  = (m_tick != 0);
        e.wrap  = (m_wrap != 0);
        return e;
    endfunction

    // Drive inputs, let one posedge happen, record the expected registered outputs.
    task automatic cycle(input logic en, input logic [1:0] sp, input logic ld, input logic [3:0] lv);
        enable = en; speed = sp; load = ld; load_value = lv;
        @(posedge clock);
        model_step();
        exp_q.push_back(model_out());
        #1;
    endtask

    task automatic run(input int n, input logic en, input logic [1:0] sp);
        for (int i = 0; i < n; i++) cycle(en, sp, 1'b0, 4'd0);
    endtask

    // Pulse resetn between edges; outputs must clear before the next posedge.
    task automatic async_reset_pulse();
        #2;
        resetn = 1'b0;
        model_reset();
        if (exp_q.size() > 0) exp_q[exp_q.size()-1] = model_out();
        #3;
        cycle(enable, speed, 1'b0, 4'd0);
        resetn = 1'b1;
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if ({count, tick, wrap} !== e) begin
                errors++;
                $display("FAIL outputs t=%0t: got count=%0d tick=%b wrap=%b, expected count=%0d tick=%b wrap=%b",
                         $time, count, tick, wrap, e.count, e.tick, e.wrap);
            end else begin
                $display("txn t=%0t count=%0d tick=%b wrap=%b ok", $time, count, tick, wrap);
            end
`ifdef RATE_COUNTER_HEX_EN
            checks++;
            if (hex0 !== glyph(int'(e.count))) begin
                errors++;
                $display("FAIL hex0 t=%0t: got %b, expected %b", $time, hex0, glyph(int'(e.count)));
            end
`endif
        end
    end

    initial begin
        // Reset held for 3 cycles with enable=1, speed=01, then run.
        resetn = 1'b0;
        run(3, 1'b1, 2'b01);
        resetn = 1'b1;
        run(13, 1'b1, 2'b01);

        // Every-clock mode from count 0 through a wrap.
        cycle(1'b1, 2'b00, 1'b1, 4'd0);
        run(20, 1'b1, 2'b00);

        // Long period, then shorten once the divider has passed the new terminal.
        cycle(1'b1, 2'b11, 1'b1, 4'd0);
        run(20, 1'b1, 2'b11);
        cycle(1'b1, 2'b11, 1'b1, 4'd3);
        run(5, 1'b1, 2'b11);
        run(3, 1'b1, 2'b01);

        // Pause mid-period with count 7 and divider 2.
        cycle(1'b1, 2'b01, 1'b1, 4'd7);
        run(2, 1'b1, 2'b01);
        run(10, 1'b0, 2'b01);
        run(4, 1'b1, 2'b01);

        // Load 14 while running every clock, across the wrap.
        run(2, 1'b1, 2'b00);
        cycle(1'b1, 2'b00, 1'b1, 4'd14);
        run(4, 1'b1, 2'b00);

        // Asynchronous reset from count 9.
        cycle(1'b0, 2'b00, 1'b1, 4'd9);
        async_reset_pulse();
        run(3, 1'b1, 2'b00);

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            logic       en;
            logic [1:0] sp;
            logic       ld;
            en = ($urandom_range(0, 9) != 0);
            sp = (i % 37 < 3) ? 2'($urandom_range(0, 3)) : speed;
            ld = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 149) == 0) begin
                async_reset_pulse();
            end else begin
                cycle(en, sp, ld, 4'($urandom_range(0, 15)));
            end
        end

        @(negedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
